// File: rtl/fibo_wb_pkg.sv
// fibo_wb_pkg
// Shared definitions for the Fibonacci Wishbone initiator:
//   - byte offsets of the Fibonacci wrapper register block
//   - wrapper identification and ack-level constants
//   - initiator FSM state encoding
//   - helper to form an absolute register address
package fibo_wb_pkg;

  localparam logic [31:0] CTRL_GET_NR_OFS  = 32'h0000_0000;
  localparam logic [31:0] CTRL_GET_ID_OFS  = 32'h0000_0004;
  localparam logic [31:0] CTRL_SET_IRQ_OFS = 32'h0000_0008;
  localparam logic [31:0] FIBO_ON_OFS      = 32'h0000_000C;
  localparam logic [31:0] FIBO_OFF_OFS     = 32'h0000_0010;
  localparam logic [31:0] FIBO_VAL_OFS     = 32'h0000_0014;
  localparam logic [31:0] CTRL_WRITE_OFS   = 32'h0000_0018;
  localparam logic [31:0] CTRL_READ_OFS    = 32'h0000_001C;
  localparam logic [31:0] CTRL_PANIC_OFS   = 32'h0000_0020;

  localparam logic [31:0] CTRL_ID = 32'h4669_626f;  // "Fibo"
  localparam logic        ACK_OK  = 1'b1;
  localparam logic        ACK_OFF = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } fibo_wb_state_e;

  function automatic logic [31:0] fibo_reg_addr(input logic [31:0] base,
                                                input logic [31:0] ofs);
    return base + ofs;
  endfunction

endpackage

// File: rtl/fibo_wb_timer.sv
// fibo_wb_timer
// Saturating up-counter with synchronous clear and count enable. tc_o is high
// while the count equals LIMIT; the counter holds there until cleared.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset (count -> 0)
//   clr_i   synchronous clear, wins over en_i
//   en_i    count enable
//   tc_o    terminal count reached (count == LIMIT)
module fibo_wb_timer
  import fibo_wb_pkg::*;
#(
  parameter int unsigned LIMIT = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

  logic [W-1:0] cnt_q;

  assign tc_o = (cnt_q == LIMIT_W);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !tc_o) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/fibo_wb_master.sv
// fibo_wb_master
// Wishbone classic single-transfer initiator for the Fibonacci register block.
// Runs one bus cycle per accepted command and returns data or a timeout error.
// When enabled, an autonomous poll engine reads the Fibonacci value register
// after POLL_PERIOD idle cycles and publishes bits [29:0] of the result.
// Ports:
//   wb_clk_i, wb_rst_ni                  clock, async active-low reset
//   cmd_valid_i/cmd_ready_o              command handshake (ready only in IDLE)
//   cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i  command fields
//   rsp_valid_o, rsp_err_o, rsp_dat_o    response pulse, timeout flag, read data
//   poll_en_i, poll_update_o, poll_value_o    poll engine control and result
//   wbm_*                                Wishbone master interface
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready for a command; poll timer runs while poll_en_i is high
// ST_BUS  | cyc/stb asserted, waiting for ack or timeout
// ST_RESP | one-cycle response / poll-update window, then back to IDLE
module fibo_wb_master
  import fibo_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS   = 32'h0300_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned POLL_PERIOD    = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [3:0]  cmd_sel_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  output logic        rsp_valid_o,
  output logic        rsp_err_o,
  output logic [31:0] rsp_dat_o,
  input  logic        poll_en_i,
  output logic        poll_update_o,
  output logic [29:0] poll_value_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  localparam logic [31:0] POLL_ADR   = fibo_reg_addr(BASE_ADDRESS, FIBO_VAL_OFS);
  localparam int unsigned POLL_LIMIT = (POLL_PERIOD > 0) ? POLL_PERIOD - 1 : 0;
  localparam int unsigned TO_LIMIT   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic        TO_EN      = (TIMEOUT_CYCLES != 0);

  fibo_wb_state_e state_q;

  logic        cmd_ready_q;
  logic        cyc_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic        is_poll_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_dat_q;
  logic        poll_update_q;
  logic [29:0] poll_value_q;

  logic cmd_accept;
  logic poll_issue;
  logic poll_tc;
  logic to_tc;
  logic timeout;

  // cmd_ready_q is the registered form of "state is IDLE"; it is low only in
  // the first IDLE cycle after reset.
  assign cmd_accept = (state_q == ST_IDLE) && cmd_ready_q && cmd_valid_i;
  assign poll_issue = (state_q == ST_IDLE) && cmd_ready_q && !cmd_valid_i
                      && poll_en_i && poll_tc;

  // Poll timer only advances on idle cycles; it stays saturated while a
  // command that pre-empted it is on the bus, so the poll follows at once.
  fibo_wb_timer #(.LIMIT(POLL_LIMIT)) u_poll_timer (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_ni),
    .clr_i  (!poll_en_i || poll_issue),
    .en_i   (poll_en_i && (state_q == ST_IDLE)),
    .tc_o   (poll_tc)
  );

  fibo_wb_timer #(.LIMIT(TO_LIMIT)) u_ack_timer (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_ni),
    .clr_i  (state_q != ST_BUS),
    .en_i   (state_q == ST_BUS),
    .tc_o   (to_tc)
  );

  // An ack in the expiry cycle takes precedence over the timeout.
  assign timeout = TO_EN && to_tc && !wbm_ack_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      cyc_q         <= 1'b0;
      we_q          <= 1'b0;
      sel_q         <= '0;
      adr_q         <= '0;
      dat_q         <= '0;
      is_poll_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_dat_q     <= '0;
      poll_update_q <= 1'b0;
      poll_value_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_accept) begin
            we_q        <= cmd_we_i;
            sel_q       <= cmd_sel_i;
            adr_q       <= cmd_adr_i;
            dat_q       <= cmd_dat_i;
            is_poll_q   <= 1'b0;
            cyc_q       <= 1'b1;
            cmd_ready_q <= 1'b0;
            state_q     <= ST_BUS;
          end else if (poll_issue) begin
            we_q        <= 1'b0;
            sel_q       <= 4'hF;
            adr_q       <= POLL_ADR;
            dat_q       <= '0;
            is_poll_q   <= 1'b1;
            cyc_q       <= 1'b1;
            cmd_ready_q <= 1'b0;
            state_q     <= ST_BUS;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end

        // Response outputs are loaded on the BUS->RESP edge so that the
        // pulses coincide with the RESP cycle.
        ST_BUS: begin
          if (wbm_ack_i) begin
            cyc_q   <= 1'b0;
            state_q <= ST_RESP;
            if (is_poll_q) begin
              poll_value_q  <= wbm_dat_i[29:0];
              poll_update_q <= 1'b1;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_dat_q   <= we_q ? 32'h0 : wbm_dat_i;
            end
          end else if (timeout) begin
            cyc_q   <= 1'b0;
            state_q <= ST_RESP;
            if (!is_poll_q) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_dat_q   <= 32'h0;
            end
          end
        end

        ST_RESP: begin
          rsp_valid_q   <= 1'b0;
          poll_update_q <= 1'b0;
          cmd_ready_q   <= 1'b1;
          state_q       <= ST_IDLE;
        end

        default: begin
          cyc_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_dat_o     = rsp_dat_q;
  assign poll_update_o = poll_update_q;
  assign poll_value_o  = poll_value_q;
  assign wbm_cyc_o     = cyc_q;
  assign wbm_stb_o     = cyc_q;
  assign wbm_we_o      = we_q;
  assign wbm_sel_o     = sel_q;
  assign wbm_adr_o     = adr_q;
  assign wbm_dat_o     = dat_q;

endmodule

// File: doc/fibo_wb_master.md
Name: fibo_wb_master

Overview:
- Wishbone classic single-transfer initiator that drives the Fibonacci wrapper's register interface from the other end of the bus.
- Accepts read/write commands on a valid/ready port and runs one bus cycle per command.
- Returns data or a timeout error on a response port.
- Optional autonomous poll engine periodically reads the Fibonacci value register; used in the test harness and by on-chip controllers in place of the management SoC.

Parameters:
- BASE_ADDRESS, 32'h0300_0000, base of the Fibonacci register block; poll address = BASE_ADDRESS + FIBO_VAL_OFS.
- TIMEOUT_CYCLES, 255, max cycles waiting for ack; 0 disables the timeout.
- POLL_PERIOD, 1024, idle cycles between poll reads (minimum 1).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_ni  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  high only in IDLE.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_sel_i  in  4  byte selects.
- cmd_adr_i  in  32  full byte address.
- cmd_dat_i  in  32  write data.
- rsp_valid_o  out  1  one-cycle pulse, command completed.
- rsp_err_o  out  1  qualifies rsp_valid_o; 1 = timeout.
- rsp_dat_o  out  32  read data; 0 for writes and errors.
- poll_en_i  in  1  enables the poll engine.
- poll_update_o  out  1  one-cycle pulse when poll_value_o is refreshed.
- poll_value_o  out  30  last good Fibonacci value, bits [29:0] of the read data.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master controls.
- wbm_sel_o  out  4  byte selects.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_ack_i  in  1  acknowledge.
- wbm_dat_i  in  32  read data.

Behaviour:
- Reset: all outputs 0, state IDLE, poll timer 0.
  - Reset is asynchronous; asserting it mid-transfer drops cyc/stb immediately.
  - No response or poll update is produced for the aborted transfer.
- FSM states: IDLE, BUS, RESP.
- IDLE: cmd_ready_o = 1. Outcomes in priority order:
  - cmd_valid_i = 1: latch we/sel/adr/dat into the bus registers and go to BUS. The command wins over a poll due in the same cycle.
  - Else, poll_en_i = 1 and the poll timer has reached POLL_PERIOD-1: issue the poll read (we = 0, sel = 4'hF, adr = poll address), mark the transfer as a poll, clear the timer, go to BUS.
  - Else: the poll timer increments while poll_en_i = 1, saturating at POLL_PERIOD-1. It clears when poll_en_i = 0.
- BUS:
  - cyc = stb = 1; we/sel/adr/dat held stable from the cycle after acceptance.
  - The wait counter starts at 0 and increments each cycle.
  - ack is sampled each cycle. On ack: capture wbm_dat_i (reads), drop cyc/stb on the next edge, go to RESP with err = 0.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 without ack: drop cyc/stb, go to RESP with err = 1 and data 0.
  - Ack in the same cycle as timeout expiry counts as success.
- RESP: lasts one cycle.
  - Command transfer: rsp_valid_o = 1 with err/data.
  - Poll transfer: no rsp_valid_o. On success, poll_value_o <= data[29:0] and poll_update_o = 1. On error, poll_value_o is unchanged and there is no pulse.
  - RESP always returns to IDLE. cmd_ready_o = 0 in BUS and RESP.
- Latency, read with zero-wait responder (ack in first BUS cycle):
  - Accept at edge 0, cyc high in cycle 1, ack seen in cycle 1.
  - rsp_valid_o high in cycle 2.
  - Next command accepted in cycle 3.
- wbm_ack_i outside BUS is ignored. rsp_dat_o and rsp_err_o hold their values until the next response.
- Write data: passed unmodified; no byte-lane masking is applied internally.

Decomposition:
- Package fibo_wb_pkg holds:
  - register offsets: CTRL_GET_NR 'h00, CTRL_GET_ID 'h04, CTRL_SET_IRQ 'h08, FIBO_ON 'h0C, FIBO_OFF 'h10, FIBO_VAL 'h14, CTRL_WRITE 'h18, CTRL_READ 'h1C, CTRL_PANIC 'h20;
  - constants: CTRL_ID 32'h4669626f, ACK_OK 1, ACK_OFF 0;
  - the FSM state enum.
- One natural sub-module, fibo_wb_timer: a shared saturating counter with clear/enable/terminal-count, instantiated twice (poll period, ack timeout).

Test Plan:
- Read CTRL_GET_ID at 0x0300_0004 against the Fibonacci wrapper (ack-generating harness) -> rsp_valid_o pulse, rsp_err_o = 0, rsp_dat_o = 32'h4669626f; cyc high exactly for the ack-wait window.
- Write 0xA5A5_1234 to 0x0300_0018 with sel 4'hF, then read 0x0300_001C -> write response data 0, err 0; read returns 0xA5A5_1234.
- Silent responder, TIMEOUT_CYCLES = 8 -> cyc/stb high exactly 8 cycles, then rsp_err_o = 1, rsp_dat_o = 0; the next command is accepted.
- poll_en_i = 1, POLL_PERIOD = 16, responder returns 0x0000_0037 on 0x0300_0014 -> poll read every 16 idle cycles plus transfer time; poll_update_o pulses, poll_value_o = 30'd55; no rsp_valid_o.
- cmd_valid_i rises in the same cycle the poll timer expires -> the command transfer goes first, then the poll read issues next IDLE.
- wb_rst_ni pulled low in the second BUS cycle with a delayed ack -> cyc/stb fall without waiting for a clock edge, no rsp_valid_o; after release cmd_ready_o = 1 and poll_value_o = 0.
